// File: rtl/fpu_accum_ctrl.sv
// Floating-point vector accumulator controller: feeds elements to an external adder,
// keeps a running total and element count, and emits the vector sum on the last element.
module fpu_accum_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_data,
  input  logic        input_last,
  input  logic        input_STB,
  output logic        input_BUSY,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  output logic        adder_input_STB,
  input  logic        adder_BUSY,
  input  logic [31:0] adder_sum,
  input  logic        adder_output_STB,
  output logic        accum_BUSY,
  output logic [31:0] output_total,
  output logic [15:0] output_count,
  output logic        output_STB,
  input  logic        output_module_BUSY
);

  typedef enum logic [1:0] {GET_X, SEND, WAIT_SUM, PUT_TOTAL} state_e;

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic        last_q, last_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] count_q, count_d;
  logic [31:0] total_q, total_d;
  logic [15:0] ocount_q, ocount_d;
  logic        in_busy_q, in_busy_d;
  logic        add_stb_q, add_stb_d;
  logic        acc_busy_q, acc_busy_d;
  logic        out_stb_q, out_stb_d;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    last_d   = last_q;
    acc_d    = acc_q;
    count_d  = count_q;
    total_d  = total_q;
    ocount_d = ocount_q;
    unique case (state_q)
      GET_X: begin
        // adder_output_STB is accepted here (accum_BUSY=0) and ignored, draining stale results
        if (input_STB && !in_busy_q) begin
          x_d     = input_data;
          last_d  = input_last;
          state_d = SEND;
        end
      end
      SEND: begin
        if (add_stb_q && !adder_BUSY) state_d = WAIT_SUM;
      end
      WAIT_SUM: begin
        if (adder_output_STB) begin
          acc_d   = adder_sum;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          if (last_q) begin
            total_d  = adder_sum;
            ocount_d = count_d;
            state_d  = PUT_TOTAL;
          end else begin
            state_d = GET_X;
          end
        end
      end
      PUT_TOTAL: begin
        if (out_stb_q && !output_module_BUSY) begin
          acc_d   = '0;
          count_d = '0;
          state_d = GET_X;
        end
      end
      default: state_d = GET_X;
    endcase
    // Handshake flags are functions of the next state so they are registered with it
    in_busy_d  = (state_d != GET_X);
    add_stb_d  = (state_d == SEND);
    acc_busy_d = (state_d == SEND) || (state_d == PUT_TOTAL);
    out_stb_d  = (state_d == PUT_TOTAL);
  end

  always_ff @(posedge clk) begin
    x_q      <= x_d;
    last_q   <= last_d;
    total_q  <= total_d;
    ocount_q <= ocount_d;
    if (rst) begin
      state_q    <= GET_X;
      acc_q      <= '0;
      count_q    <= '0;
      in_busy_q  <= 1'b0;
      add_stb_q  <= 1'b0;
      acc_busy_q <= 1'b0;
      out_stb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      in_busy_q  <= in_busy_d;
      add_stb_q  <= add_stb_d;
      acc_busy_q <= acc_busy_d;
      out_stb_q  <= out_stb_d;
    end
  end

  // acc and x only change outside SEND/WAIT_SUM, so the operands hold through the adder transfer
  assign adder_a         = acc_q;
  assign adder_b         = x_q;
  assign adder_input_STB = add_stb_q;
  assign input_BUSY      = in_busy_q;
  assign accum_BUSY      = acc_busy_q;
  assign output_STB      = out_stb_q;
  assign output_total    = total_q;
  assign output_count    = ocount_q;

endmodule

// File: tb/tb_fpu_accum_ctrl.sv
// Directed bench for fpu_accum_ctrl with a fixed-latency adder model whose sums
// come from a hand-computed table of the operand pairs these vectors produce.
module tb_fpu_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_data = '0;
  logic        input_last = 1'b0;
  logic        input_STB = 1'b0;
  logic        input_BUSY;
  logic [31:0] adder_a, adder_b;
  logic        adder_input_STB;
  logic        adder_BUSY = 1'b0;
  logic [31:0] adder_sum = '0;
  logic        adder_output_STB = 1'b0;
  logic        accum_BUSY;
  logic [31:0] output_total;
  logic [15:0] output_count;
  logic        output_STB;
  logic        output_module_BUSY = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  fpu_accum_ctrl dut (
    .clk(clk), .rst(rst),
    .input_data(input_data), .input_last(input_last), .input_STB(input_STB), .input_BUSY(input_BUSY),
    .adder_a(adder_a), .adder_b(adder_b), .adder_input_STB(adder_input_STB), .adder_BUSY(adder_BUSY),
    .adder_sum(adder_sum), .adder_output_STB(adder_output_STB), .accum_BUSY(accum_BUSY),
    .output_total(output_total), .output_count(output_count), .output_STB(output_STB),
    .output_module_BUSY(output_module_BUSY)
  );

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h00000000, 32'h3F800000}: return 32'h3F800000;
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40400000, 32'h40400000}: return 32'h40C00000;
      {32'h00000000, 32'hC0000000}: return 32'hC0000000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h3F800000}: return 32'h40400000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      {32'h00000000, 32'h40000000}: return 32'h40000000;
      {32'h00000000, 32'h7F800000}: return 32'h7F800000;
      {32'h7F800000, 32'hFF800000}: return 32'h7FC00000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Adder model: busy from operand accept until its result is taken (3-cycle latency)
  logic [31:0] add_res = '0;
  int          add_cnt = 0;
  always @(posedge clk) begin
    if (adder_input_STB && !adder_BUSY) begin
      add_res    <= fadd(adder_a, adder_b);
      add_cnt    <= 3;
      adder_BUSY <= 1'b1;
    end else if (adder_BUSY && !adder_output_STB) begin
      if (add_cnt == 1) begin
        adder_output_STB <= 1'b1;
        adder_sum        <= add_res;
      end
      add_cnt <= add_cnt - 1;
    end else if (adder_output_STB && !accum_BUSY) begin
      adder_output_STB <= 1'b0;
      adder_BUSY       <= 1'b0;
    end
  end

  int unsigned accept_cnt = 0;
  int unsigned out_cnt = 0;
  logic [31:0] last_total = '0;
  logic [15:0] last_count = '0;
  logic [31:0] last_adder_a = '1;
  always @(posedge clk) begin
    if (input_STB && !input_BUSY) accept_cnt <= accept_cnt + 1;
    if (adder_input_STB && !adder_BUSY) last_adder_a <= adder_a;
    if (output_STB && !output_module_BUSY) begin
      out_cnt    <= out_cnt + 1;
      last_total <= output_total;
      last_count <= output_count;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_elem(input logic [31:0] d, input logic l, output bit ok);
    ok = 1'b0;
    input_data = d;
    input_last = l;
    input_STB  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!input_BUSY) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    input_STB  = 1'b0;
    input_last = 1'b0;
  endtask

  task automatic wait_out(input int unsigned target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (input_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_input_BUSY got %b want 0", input_BUSY); end
    n_checks++; if (adder_input_STB !== 1'b0) begin n_fail++; $display("FAIL reset_adder_input_STB got %b want 0", adder_input_STB); end
    n_checks++; if (output_STB !== 1'b0) begin n_fail++; $display("FAIL reset_output_STB got %b want 0", output_STB); end
    n_checks++; if (accum_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_accum_BUSY got %b want 0", accum_BUSY); end
  endtask

  task automatic test_sum3();
    bit ok, ok2, ok3, okw;
    int unsigned base = out_cnt;
    send_elem(32'h3F800000, 1'b0, ok);
    send_elem(32'h40000000, 1'b0, ok2);
    send_elem(32'h40400000, 1'b1, ok3);
    wait_out(base + 1, okw);
    repeat (5) tick();
    n_checks++; if (!(ok && ok2 && ok3 && okw)) begin n_fail++; $display("FAIL sum3_timeout got %b%b%b%b want 1111", ok, ok2, ok3, okw); end
    n_checks++; if (out_cnt !== base + 1) begin n_fail++; $display("FAIL sum3_pulses got %0d want %0d", out_cnt - base, 1); end
    n_checks++; if (last_total !== 32'h40C00000) begin n_fail++; $display("FAIL sum3_total got %h want 40c00000", last_total); end
    n_checks++; if (last_count !== 16'd3) begin n_fail++; $display("FAIL sum3_count got %0d want 3", last_count); end
    n_checks++; if (input_BUSY !== 1'b0) begin n_fail++; $display("FAIL sum3_idle_input_BUSY got %b want 0", input_BUSY); end
  endtask

  task automatic test_single();
    bit ok, okw;
    int unsigned base = out_cnt;
    send_elem(32'hC0000000, 1'b1, ok);
    wait_out(base + 1, okw);
    n_checks++; if (!(ok && okw)) begin n_fail++; $display("FAIL single_timeout got %b%b want 11", ok, okw); end
    n_checks++; if (last_total !== 32'hC0000000) begin n_fail++; $display("FAIL single_total got %h want c0000000", last_total); end
    n_checks++; if (last_count !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", last_count); end
    n_checks++; if (last_adder_a !== 32'h00000000) begin n_fail++; $display("FAIL single_first_operand got %h want 00000000", last_adder_a); end
  endtask

  task automatic test_out_busy_hold();
    bit ok, okw;
    int unsigned base = out_cnt;
    output_module_BUSY = 1'b1;
    send_elem(32'h3F800000, 1'b1, ok);
    okw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (output_STB) begin okw = 1'b1; break; end
      tick();
    end
    n_checks++; if (!(ok && okw)) begin n_fail++; $display("FAIL hold_timeout got %b%b want 11", ok, okw); end
    n_checks++; if (last_adder_a !== 32'h00000000) begin n_fail++; $display("FAIL acc_cleared_after_single got %h want 00000000", last_adder_a); end
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (output_STB !== 1'b1) begin n_fail++; $display("FAIL hold_output_STB cyc %0d got %b want 1", c, output_STB); end
      n_checks++; if (output_total !== 32'h3F800000) begin n_fail++; $display("FAIL hold_total cyc %0d got %h want 3f800000", c, output_total); end
      n_checks++; if (input_BUSY !== 1'b1) begin n_fail++; $display("FAIL hold_input_BUSY cyc %0d got %b want 1", c, input_BUSY); end
      tick();
    end
    n_checks++; if (out_cnt !== base) begin n_fail++; $display("FAIL hold_no_early_transfer got %0d want 0", out_cnt - base); end
    output_module_BUSY = 1'b0;
    tick();
    n_checks++; if (out_cnt !== base + 1) begin n_fail++; $display("FAIL hold_release_transfer got %0d want 1", out_cnt - base); end
    n_checks++; if (output_STB !== 1'b0) begin n_fail++; $display("FAIL hold_release_output_STB got %b want 0", output_STB); end
    n_checks++; if (output_total !== 32'h3F800000) begin n_fail++; $display("FAIL hold_total_after got %h want 3f800000", output_total); end
  endtask

  task automatic test_back_to_back();
    bit okw;
    int unsigned base_acc = accept_cnt;
    int unsigned base = out_cnt;
    input_data = 32'h3F800000;
    input_last = 1'b0;
    input_STB  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (accept_cnt - base_acc >= 4) break;
      input_last = (accept_cnt - base_acc == 3);
      tick();
    end
    input_STB  = 1'b0;
    input_last = 1'b0;
    wait_out(base + 1, okw);
    n_checks++; if (!okw) begin n_fail++; $display("FAIL b2b_timeout got 0 want 1"); end
    n_checks++; if (accept_cnt - base_acc !== 4) begin n_fail++; $display("FAIL b2b_accepts got %0d want 4", accept_cnt - base_acc); end
    n_checks++; if (last_total !== 32'h40800000) begin n_fail++; $display("FAIL b2b_total got %h want 40800000", last_total); end
    n_checks++; if (last_count !== 16'd4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", last_count); end
  endtask

  task automatic test_reset_wait_sum();
    bit ok, ok2, okb, okd, okw;
    int unsigned base;
    send_elem(32'h40000000, 1'b0, ok);
    okb = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (adder_BUSY) begin okb = 1'b1; break; end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (input_BUSY !== 1'b0) begin n_fail++; $display("FAIL rstws_input_BUSY got %b want 0", input_BUSY); end
    n_checks++; if (accum_BUSY !== 1'b0) begin n_fail++; $display("FAIL rstws_accum_BUSY got %b want 0", accum_BUSY); end
    okd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!adder_BUSY) begin okd = 1'b1; break; end
      tick();
    end
    base = out_cnt;
    send_elem(32'h3F800000, 1'b1, ok2);
    wait_out(base + 1, okw);
    n_checks++; if (!(ok && okb && okd && ok2 && okw)) begin n_fail++; $display("FAIL rstws_timeout got %b%b%b%b%b want 11111", ok, okb, okd, ok2, okw); end
    n_checks++; if (last_total !== 32'h3F800000) begin n_fail++; $display("FAIL rstws_total got %h want 3f800000", last_total); end
    n_checks++; if (last_count !== 16'd1) begin n_fail++; $display("FAIL rstws_count got %0d want 1", last_count); end
  endtask

  task automatic test_nan();
    bit ok, ok2, okw;
    int unsigned base = out_cnt;
    send_elem(32'h7F800000, 1'b0, ok);
    send_elem(32'hFF800000, 1'b1, ok2);
    wait_out(base + 1, okw);
    n_checks++; if (!(ok && ok2 && okw)) begin n_fail++; $display("FAIL nan_timeout got %b%b%b want 111", ok, ok2, okw); end
    n_checks++; if (last_total[30:23] !== 8'hFF || last_total[22:0] == 23'd0) begin n_fail++; $display("FAIL nan_total got %h want NaN", last_total); end
    n_checks++; if (last_total !== 32'h7FC00000) begin n_fail++; $display("FAIL nan_adder_value got %h want 7fc00000", last_total); end
    n_checks++; if (last_count !== 16'd2) begin n_fail++; $display("FAIL nan_count got %0d want 2", last_count); end
  endtask

  initial begin
    test_reset();
    test_sum3();
    test_single();
    test_out_busy_hold();
    test_back_to_back();
    test_reset_wait_sum();
    test_nan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_accum_ctrl.md
FPU_ACCUM_CTRL -- requirements
Module: fpu_accum_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, synchronous, active-high
- input_data  input  32  IEEE-754 single operand to accumulate
- input_last  input  1  marks final element of a vector; sampled with input_data
- input_STB  input  1  input_data/input_last valid
- input_BUSY  output  1  block cannot accept an element
- adder_a  output  32  operand a to adder (running total)
- adder_b  output  32  operand b to adder (current element)
- adder_input_STB  output  1  adder operands valid
- adder_BUSY  input  1  adder busy
- adder_sum  input  32  adder result
- adder_output_STB  input  1  adder result valid
- accum_BUSY  output  1  drives the adder's output_module_BUSY; low means the result is accepted
- output_total  output  32  vector sum
- output_count  output  16  elements in the vector
- output_STB  output  1  output_total/output_count valid
- output_module_BUSY  input  1  downstream busy

Function
REQ-002 SHALL implement a 4-state FSM: GET_X, SEND, WAIT_SUM, PUT_TOTAL.
REQ-003 A transfer on any STB/BUSY pair SHALL occur on the edge where STB=1 and BUSY=0.
REQ-004 GET_X:
- input_BUSY=0.
- On a transfer, latch input_data into x and input_last into last.
- Set input_BUSY=1 and go to SEND.
REQ-005 SEND: drive adder_a=acc, adder_b=x and adder_input_STB=1, all registered.
REQ-006 SEND: on the edge where adder_input_STB=1 and adder_BUSY=0, clear adder_input_STB and go to WAIT_SUM.
REQ-007 adder_a and adder_b SHALL stay constant from SEND entry until the cycle after the adder transfer.
REQ-008 WAIT_SUM: accum_BUSY=0. On adder_output_STB=1:
- acc <= adder_sum.
- count <= count+1; count saturates at 16'hFFFF.
- Go to PUT_TOTAL if last=1, otherwise return to GET_X.
REQ-009 accum_BUSY SHALL be 1 in SEND and PUT_TOTAL, and 0 in GET_X and WAIT_SUM.
REQ-010 In GET_X, any adder_output_STB pulse SHALL be accepted and discarded, leaving acc and count unchanged; this drains a stale adder result.
REQ-011 PUT_TOTAL: output_STB=1, output_total=acc, output_count=count.
REQ-012 PUT_TOTAL: on the edge where output_STB=1 and output_module_BUSY=0:
- Clear output_STB.
- acc <= 32'h00000000 and count <= 0.
- Go to GET_X.
REQ-013 output_total and output_count SHALL hold their last valid values while output_STB=0.
REQ-014 The first element of every vector SHALL be added to acc=+0 (32'h00000000); a single-element vector yields 0+x.
REQ-015 The block SHALL NOT interpret float fields; NaN, Inf and denormal results are whatever the adder returns.
REQ-016 Minimum input-to-input spacing SHALL be one full adder round trip; input_BUSY stays 1 from element accept until re-entry to GET_X.
REQ-017 input_STB asserted while input_BUSY=1 SHALL be ignored and SHALL NOT be lost; it is accepted once GET_X is re-entered.

Reset
REQ-018 While rst=1 at a clock edge:
- state <= GET_X.
- input_BUSY, adder_input_STB, output_STB and accum_BUSY <= 0.
- acc <= 32'h00000000 and count <= 0.
REQ-019 rst SHALL take priority over every FSM transition in the same cycle.
REQ-020 output_total, output_count, adder_a and adder_b SHALL be don't-care after reset.
REQ-021 Reset in SEND or WAIT_SUM SHALL abandon the element; a late adder result is drained per REQ-010.

Verification
REQ-022 Bench SHALL instantiate the team FPU adder on the adder_* ports and cover:
- Elements 3F800000, 40000000, 40400000 (last on third), output_module_BUSY=0 -> one output_STB pulse, output_total=40C00000, output_count=3.
- Single element C0000000 with last=1 -> output_total=C0000000, output_count=1; acc cleared to 00000000 afterwards.
- output_module_BUSY held 1 for 10 cycles in PUT_TOTAL -> output_STB stays 1 and output_total is stable; input_BUSY=1 throughout; transfer on the first cycle busy drops.
- input_STB held high continuously with 4 elements of 3F800000 -> each accepted exactly once, no element dropped; total=40800000, count=4.
- rst pulsed during WAIT_SUM, then a new vector {3F800000 last} -> stale adder result discarded; output_total=3F800000, output_count=1.
- Elements 7F800000 then FF800000 (last) -> output_total=NaN as produced by the adder (exponent FF, nonzero mantissa), count=2.
